stream_rr_arb: RTL and testbench

Round-robin arbiter that shares one 32-bit valid/ready stream (the `bar` data/valid/ready bundle) between N requesting producers. Each requester is granted the output for a burst of up to BURST beats, then the grant rotates. The output is registered, so the block sits between producer-side stream ports and a single downstream consumer.

---
 rtl/stream_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 29 ++
 rtl/stream_rr_arb.sv | 122 ++++++++++++
 tb/tb_stream_rr_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types for the round-robin stream arbiter.
// Holds the data width, the FSM state encoding and the data word type.
package stream_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority requester search: first set bit at or after ptr+1, wrapping modulo N.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos_s;
  logic             hit_s;

  // Walk offsets 1..N from ptr; the first hit is latched by the running 'any' flag
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int i = 1; i <= N; i++) begin
      pos_s = IDX_W'((int'(ptr) + i) % N);
      hit_s = !any && req[pos_s];
      idx   = hit_s ? pos_s : idx;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/stream_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready stream among N producers,
// granting each requester a burst of up to BURST beats before rotating.
module stream_rr_arb
  import stream_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int BURST = 4,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0][DATA_W-1:0] in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic [CNT_W-1:0] count_r;
  data_t            out_data_r;
  logic             out_valid_r;

  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             slot_open_s;
  logic             cur_valid_s;
  logic             last_beat_s;
  logic             accept_s;
  logic             release_s;

  rr_pick #(.N(N)) u_pick (
    .req (in_valid),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign slot_open_s = !out_valid_r || out_ready;
  assign cur_valid_s = in_valid[grant_idx_r];
  assign last_beat_s = (count_r == CNT_W'(BURST - 1));

  // Next-state, ready generation and beat/release decisions
  always_comb begin
    in_ready    = '0;
    accept_s    = 1'b0;
    release_s   = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = ARB_GRANT;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        in_ready[grant_idx_r] = slot_open_s;
        accept_s  = cur_valid_s && slot_open_s;
        // A dropped valid releases even under backpressure; a stall with valid high never does
        release_s = !cur_valid_s || (accept_s && last_beat_s);
        if (release_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_GRANT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Arbitration state: FSM, rotation pointer, grantee and beat count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ARB_IDLE;
      ptr_r       <= IDX_W'(N - 1);
      grant_idx_r <= '0;
      count_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ARB_IDLE && pick_any_s) begin
        grant_idx_r <= pick_idx_s;
        count_r     <= '0;
      end else if (release_s) begin
        count_r <= '0;
      end else if (accept_s) begin
        count_r <= count_r + CNT_W'(1);
      end
      if (release_s) begin
        ptr_r <= grant_idx_r;
      end
    end
  end

  // Output register: load on accepted beat, drop valid once the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_data_r  <= in_data[grant_idx_r];
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign grant_valid = (state_r == ARB_GRANT);
  assign grant_idx   = grant_idx_r;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed scoreboard bench for stream_rr_arb: N=4/BURST=4 instance plus an N=2/BURST=1 instance.
module tb_stream_rr_arb;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0][31:0]  in_data;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  logic [1:0][31:0]  in_data1;
  logic [1:0]        in_valid1;
  logic [1:0]        in_ready1;
  logic [31:0]       out_data1;
  logic              out_valid1;
  logic              out_ready1;
  logic              grant_valid1;
  logic [0:0]        grant_idx1;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] src_mem [4][16];
  int          src_rd [4];
  int          src_wr [4];
  logic [3:0]  fire;
  logic [1:0]  fire1;
  int          c0, c1;
  logic        en1, ordy_nxt, rst_nxt;
  logic [31:0] exp_q [$];
  logic [31:0] exp1_q [$];
  logic [10:0] gv_v, ov_v;
  logic [9:0]  gi_v;
  logic [7:0]  gv1_v;

  always #5 clk = ~clk;

  stream_rr_arb #(.N(4), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  stream_rr_arb #(.N(2), .BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .grant_valid(grant_valid1), .grant_idx(grant_idx1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = (src_rd[i] < src_wr[i]);
      in_data[i]  = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 32'h0;
    end
    out_ready   = ordy_nxt;
    rst_n       = rst_nxt;
    in_valid1   = en1 ? 2'b11 : 2'b00;
    in_data1[0] = 32'h1000 + 32'(c0);
    in_data1[1] = 32'h2000 + 32'(c1);
    out_ready1  = 1'b1;
  endtask

  // Advance one cycle: retire handshakes, redrive after the edge, sample and score on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i]) src_rd[i]++;
    if (fire1[0]) c0++;
    if (fire1[1]) c1++;
    drive();
    @(negedge clk);
    fire  = in_valid & in_ready;
    fire1 = in_valid1 & in_ready1;
    if (out_valid && out_ready) begin
      ncmp++;
      assert (exp_q.size() > 0) else begin
        nerr++;
        $error("FAIL sb0_extra observed=%h expected=none", out_data);
      end
      if (exp_q.size() > 0) chk("sb0_data", out_data, exp_q.pop_front());
    end
    if (out_valid1 && out_ready1) begin
      ncmp++;
      assert (exp1_q.size() > 0) else begin
        nerr++;
        $error("FAIL sb1_extra observed=%h expected=none", out_data1);
      end
      if (exp1_q.size() > 0) chk("sb1_data", out_data1, exp1_q.pop_front());
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    fire = 4'b0;
  endtask

  task automatic load(input int r, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      src_mem[r][src_wr[r]] = base + 32'(k);
      src_wr[r]++;
    end
  endtask

  task automatic exp_burst(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(k));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 80 && (exp_q.size() + exp1_q.size()) > 0; k++) tick();
    chk(tag, 32'(exp_q.size() + exp1_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    clr();
    fire1 = 2'b0; c0 = 0; c1 = 0; en1 = 1'b0;
    ordy_nxt = 1'b1; rst_nxt = 1'b0;
    drive();
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ptr", 32'(dut.ptr_r), 32'd3);
    chk("rst_count", 32'(dut.count_r), 32'd0);
    rst_nxt = 1'b1;
    tick();

    // Single requester: two bursts of four with one idle bubble between them
    load(1, 32'h10, 8);
    exp_burst(32'h10, 8);
    tick();
    gv_v[0] = grant_valid;
    ov_v[0] = out_valid;
    for (int k = 1; k <= 10; k++) begin
      tick();
      gv_v[k]   = grant_valid;
      ov_v[k]   = out_valid;
      gi_v[k-1] = (grant_idx == 2'd1);
    end
    chk("single_grant_pattern", 32'(gv_v), 32'h3DE);
    chk("single_valid_pattern", 32'(ov_v), 32'h7BC);
    chk("single_grant_idx", 32'(gi_v), 32'h3FF);
    drain("single_drain");
    chk("single_hold_data", out_data, 32'h17);
    chk("single_drained_valid", 32'(out_valid), 32'd0);

    // Contention: req0 and req2 alternate bursts, starting after the last grantee (1)
    clr();
    load(0, 32'hA000, 12);
    load(2, 32'hC000, 12);
    for (int b = 0; b < 3; b++) begin
      exp_burst(32'hC000 + 32'(4 * b), 4);
      exp_burst(32'hA000 + 32'(4 * b), 4);
    end
    drain("contend_drain");

    // Backpressure: five stalled cycles mid-burst
    clr();
    load(1, 32'h30, 4);
    exp_burst(32'h30, 4);
    repeat (3) tick();
    ordy_nxt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, 32'h31);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_count", 32'(dut.count_r), 32'd2);
      chk("stall_grant", 32'(grant_valid), 32'd1);
    end
    ordy_nxt = 1'b1;
    drain("stall_drain");

    // Early release by req3 after two beats, then wrap-around to pending req0
    clr();
    load(3, 32'h40, 2);
    load(0, 32'h50, 2);
    exp_burst(32'h40, 2);
    exp_burst(32'h50, 2);
    repeat (5) tick();
    chk("early_idle", 32'(grant_valid), 32'd0);
    chk("early_ptr", 32'(dut.ptr_r), 32'd3);
    chk("early_hold_idx", 32'(grant_idx), 32'd3);
    tick();
    chk("early_wrap_grant", 32'(grant_valid), 32'd1);
    chk("early_wrap_idx", 32'(grant_idx), 32'd0);
    drain("early_drain");

    // Reset during beat 2 of a req1 burst; only the first beat reaches the consumer
    clr();
    load(1, 32'h60, 4);
    load(0, 32'h70, 4);
    exp_burst(32'h60, 1);
    repeat (2) tick();
    rst_nxt = 1'b0;
    tick();
    clr();
    rst_nxt = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("mid_rst_ptr", 32'(dut.ptr_r), 32'd3);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    load(0, 32'h70, 2);
    load(1, 32'h62, 2);
    exp_burst(32'h70, 2);
    exp_burst(32'h62, 2);
    repeat (2) tick();
    chk("post_rst_grant_idx", 32'(grant_idx), 32'd0);
    drain("post_rst_drain");

    // N=2, BURST=1: grants alternate every beat with a bubble between
    en1 = 1'b1;
    exp1_q.push_back(32'h1000);
    exp1_q.push_back(32'h2000);
    exp1_q.push_back(32'h1001);
    exp1_q.push_back(32'h2001);
    tick();
    gv1_v[0] = grant_valid1;
    for (int k = 1; k < 8; k++) begin
      tick();
      gv1_v[k] = grant_valid1;
    end
    en1 = 1'b0;
    chk("b1_grant_pattern", 32'(gv1_v), 32'hAA);
    drain("b1_drain");
    chk("b1_beats_r0", 32'(c0), 32'd2);
    chk("b1_beats_r1", 32'(c1), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
